// File: rtl/msb_arbiter_if.sv
// Request/grant bundle for the 3-requester MSB-priority arbiter.
// The master side drives requests and release strobes; the slave side is the arbiter.
interface msb_arbiter_if;
    logic [2:0] req;
    logic [2:0] done;
    logic [2:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       timeout;

    modport master (output req, done, input gnt, gnt_idx, busy, timeout);
    modport slave  (input req, done, output gnt, gnt_idx, busy, timeout);
endinterface

// File: rtl/msb_arbiter.sv
// Fixed MSB-priority arbiter with a per-owner hold limit; an owner that hits the
// limit is masked out for the next arbitration so the others get a turn.
module msb_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    msb_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [1:0] gnt_idx_q, gnt_idx_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;
    logic [2:0] mask_q, mask_d;
    logic [7:0] hcnt_q, hcnt_d;

    logic [2:0] masked_req;
    logic [2:0] eff_req;
    logic [1:0] msb_idx;
    logic       release_now;
    logic       at_limit;

    always_comb begin
        masked_req = bus.req & ~mask_q;
        // The mask only deflects arbitration when someone else is actually asking.
        eff_req    = (masked_req != 3'b000) ? masked_req : bus.req;

        msb_idx = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (eff_req[i]) msb_idx = 2'(i);
        end

        release_now = (|(bus.done & gnt_q)) | ~(|(bus.req & gnt_q));
        at_limit    = (hcnt_q == HOLD_LAST);
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        hcnt_d    = hcnt_q;
        mask_d    = mask_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (eff_req != 3'b000) begin
                    state_d   = GRANT;
                    gnt_d     = 3'b001 << msb_idx;
                    gnt_idx_d = msb_idx;
                    hcnt_d    = 8'd0;
                    mask_d    = 3'b000;
                end
            end
            GRANT: begin
                // A voluntary release beats the hold limit in the same cycle.
                if (release_now) begin
                    state_d = GAP;
                    gnt_d   = 3'b000;
                end else if (at_limit) begin
                    state_d   = GAP;
                    gnt_d     = 3'b000;
                    mask_d    = gnt_q;
                    timeout_d = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
            end
        endcase

        busy_d = (state_d == GRANT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 3'b000;
            gnt_idx_q <= 2'b00;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            mask_q    <= 3'b000;
            hcnt_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            mask_q    <= mask_d;
            hcnt_q    <= hcnt_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_msb_arbiter.sv
// Directed and random checks of msb_arbiter; observed word is
// {gnt, gnt_idx (zeroed when not busy), busy, timeout}.
module tb_msb_arbiter;
    localparam int unsigned MAX_HOLD = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    msb_arbiter_if bus_if ();

    msb_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] observe;
        return {bus_if.gnt, bus_if.busy ? bus_if.gnt_idx : 2'b00, bus_if.busy, bus_if.timeout};
    endfunction

    task automatic test_reset;
        logic [6:0] obs;
        rst = 1'b1;
        bus_if.req  = 3'b111;
        bus_if.done = 3'b000;
        tick();
        tick();
        obs = observe();
        n_cmp++;
        if (obs !== 7'b000_00_0_0) begin
            n_err++;
            $display("FAIL reset: got %b, expected %b", obs, 7'b000_00_0_0);
        end
        $display("reset: out=%b", obs);
        bus_if.req = 3'b000;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        logic [2:0] rv[$];
        logic [2:0] dv[$];
        logic [6:0] ev[$];
        logic [6:0] obs;
        rv = '{3'b001, 3'b000, 3'b000};
        dv = '{3'b000, 3'b000, 3'b000};
        ev = '{7'b001_00_1_0, 7'b000_00_0_0, 7'b000_00_0_0};
        for (int k = 0; k < rv.size(); k++) begin
            bus_if.req = rv[k]; bus_if.done = dv[k];
            tick();
            obs = observe();
            n_cmp++;
            if (obs !== ev[k]) begin
                n_err++;
                $display("FAIL single step %0d: got %b, expected %b", k, obs, ev[k]);
            end
            $display("single step %0d: req=%b done=%b out=%b", k, rv[k], dv[k], obs);
        end
    endtask

    task automatic test_release;
        logic [2:0] rv[$];
        logic [2:0] dv[$];
        logic [6:0] ev[$];
        logic [6:0] obs;
        rv = '{3'b111, 3'b111, 3'b011, 3'b011, 3'b000, 3'b000};
        dv = '{3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
        ev = '{7'b100_10_1_0, 7'b000_00_0_0, 7'b000_00_0_0,
               7'b010_01_1_0, 7'b000_00_0_0, 7'b000_00_0_0};
        for (int k = 0; k < rv.size(); k++) begin
            bus_if.req = rv[k]; bus_if.done = dv[k];
            tick();
            obs = observe();
            n_cmp++;
            if (obs !== ev[k]) begin
                n_err++;
                $display("FAIL release step %0d: got %b, expected %b", k, obs, ev[k]);
            end
            $display("release step %0d: req=%b done=%b out=%b", k, rv[k], dv[k], obs);
        end
    endtask

    task automatic test_timeout;
        logic [2:0] rv[$];
        logic [2:0] dv[$];
        logic [6:0] ev[$];
        logic [6:0] obs;
        for (int i = 0; i < MAX_HOLD; i++) begin rv.push_back(3'b101); dv.push_back(3'b000); ev.push_back(7'b100_10_1_0); end
        rv.push_back(3'b101); dv.push_back(3'b000); ev.push_back(7'b000_00_0_1);
        rv.push_back(3'b101); dv.push_back(3'b000); ev.push_back(7'b000_00_0_0);
        for (int i = 0; i < MAX_HOLD; i++) begin rv.push_back(3'b101); dv.push_back(3'b000); ev.push_back(7'b001_00_1_0); end
        rv.push_back(3'b101); dv.push_back(3'b000); ev.push_back(7'b000_00_0_1);
        rv.push_back(3'b101); dv.push_back(3'b000); ev.push_back(7'b000_00_0_0);
        rv.push_back(3'b101); dv.push_back(3'b000); ev.push_back(7'b100_10_1_0);
        rv.push_back(3'b000); dv.push_back(3'b000); ev.push_back(7'b000_00_0_0);
        rv.push_back(3'b000); dv.push_back(3'b000); ev.push_back(7'b000_00_0_0);
        for (int k = 0; k < rv.size(); k++) begin
            bus_if.req = rv[k]; bus_if.done = dv[k];
            tick();
            obs = observe();
            n_cmp++;
            if (obs !== ev[k]) begin
                n_err++;
                $display("FAIL timeout step %0d: got %b, expected %b", k, obs, ev[k]);
            end
            $display("timeout step %0d: req=%b done=%b out=%b", k, rv[k], dv[k], obs);
        end
    endtask

    task automatic test_release_at_limit;
        logic [2:0] rv[$];
        logic [2:0] dv[$];
        logic [6:0] ev[$];
        logic [6:0] obs;
        for (int i = 0; i < MAX_HOLD; i++) begin rv.push_back(3'b101); dv.push_back(3'b000); ev.push_back(7'b100_10_1_0); end
        // done arrives while hcnt sits at MAX_HOLD-1: plain release, no timeout, no mask
        rv.push_back(3'b101); dv.push_back(3'b100); ev.push_back(7'b000_00_0_0);
        rv.push_back(3'b101); dv.push_back(3'b000); ev.push_back(7'b000_00_0_0);
        rv.push_back(3'b101); dv.push_back(3'b000); ev.push_back(7'b100_10_1_0);
        rv.push_back(3'b000); dv.push_back(3'b000); ev.push_back(7'b000_00_0_0);
        rv.push_back(3'b000); dv.push_back(3'b000); ev.push_back(7'b000_00_0_0);
        for (int k = 0; k < rv.size(); k++) begin
            bus_if.req = rv[k]; bus_if.done = dv[k];
            tick();
            obs = observe();
            n_cmp++;
            if (obs !== ev[k]) begin
                n_err++;
                $display("FAIL limit_release step %0d: got %b, expected %b", k, obs, ev[k]);
            end
            $display("limit_release step %0d: req=%b done=%b out=%b", k, rv[k], dv[k], obs);
        end
    endtask

    task automatic test_ignore_non_owner;
        logic [2:0] rv[$];
        logic [2:0] dv[$];
        logic [6:0] ev[$];
        logic [6:0] obs;
        rv = '{3'b001, 3'b111, 3'b111, 3'b111, 3'b100, 3'b100, 3'b000, 3'b000};
        dv = '{3'b000, 3'b110, 3'b110, 3'b001, 3'b111, 3'b111, 3'b000, 3'b000};
        ev = '{7'b001_00_1_0, 7'b001_00_1_0, 7'b001_00_1_0, 7'b000_00_0_0,
               7'b000_00_0_0, 7'b100_10_1_0, 7'b000_00_0_0, 7'b000_00_0_0};
        for (int k = 0; k < rv.size(); k++) begin
            bus_if.req = rv[k]; bus_if.done = dv[k];
            tick();
            obs = observe();
            n_cmp++;
            if (obs !== ev[k]) begin
                n_err++;
                $display("FAIL ignore step %0d: got %b, expected %b", k, obs, ev[k]);
            end
            $display("ignore step %0d: req=%b done=%b out=%b", k, rv[k], dv[k], obs);
        end
    endtask

    task automatic test_reset_mid_grant;
        logic       sv[$];
        logic [2:0] rv[$];
        logic [6:0] ev[$];
        logic [6:0] obs;
        sv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        rv = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
        ev = '{7'b010_01_1_0, 7'b010_01_1_0, 7'b000_00_0_0,
               7'b010_01_1_0, 7'b000_00_0_0, 7'b000_00_0_0};
        for (int k = 0; k < rv.size(); k++) begin
            rst = sv[k]; bus_if.req = rv[k]; bus_if.done = 3'b000;
            tick();
            obs = observe();
            n_cmp++;
            if (obs !== ev[k]) begin
                n_err++;
                $display("FAIL rst_mid step %0d: got %b, expected %b", k, obs, ev[k]);
            end
            $display("rst_mid step %0d: rst=%b req=%b out=%b", k, sv[k], rv[k], obs);
        end
        rst = 1'b0;
    endtask

    task automatic test_random;
        int run_len;
        int n_timeouts;
        run_len = 0;
        n_timeouts = 0;
        bus_if.req = 3'b000; bus_if.done = 3'b000;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 7) == 0) bus_if.req = 3'($urandom_range(0, 7));
            bus_if.done = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            tick();
            n_cmp++;
            if (!$onehot0(bus_if.gnt)) begin
                n_err++;
                $display("FAIL rand_onehot cycle %0d: gnt=%b, expected one-hot or zero", c, bus_if.gnt);
            end
            n_cmp++;
            if ((bus_if.gnt != 3'b000) !== bus_if.busy) begin
                n_err++;
                $display("FAIL rand_busy cycle %0d: gnt=%b busy=%b, expected busy==(gnt!=0)", c, bus_if.gnt, bus_if.busy);
            end
            if (bus_if.busy) begin
                run_len++;
                n_cmp++;
                if (bus_if.gnt !== (3'b001 << bus_if.gnt_idx)) begin
                    n_err++;
                    $display("FAIL rand_idx cycle %0d: gnt=%b idx=%b, expected gnt bit at idx", c, bus_if.gnt, bus_if.gnt_idx);
                end
                n_cmp++;
                if (run_len > MAX_HOLD) begin
                    n_err++;
                    $display("FAIL rand_hold cycle %0d: run=%0d, expected <= %0d", c, run_len, MAX_HOLD);
                end
            end else begin
                if (bus_if.timeout) begin
                    n_timeouts++;
                    n_cmp++;
                    if (run_len != MAX_HOLD) begin
                        n_err++;
                        $display("FAIL rand_timeout cycle %0d: preceding run=%0d, expected %0d", c, run_len, MAX_HOLD);
                    end
                end
                run_len = 0;
            end
        end
        n_cmp++;
        if (n_timeouts == 0) begin
            n_err++;
            $display("FAIL rand_timeout_seen: got 0 timeouts, expected at least 1");
        end
        $display("random: 10000 cycles, %0d timeouts", n_timeouts);
        bus_if.req = 3'b000; bus_if.done = 3'b000;
        tick();
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus_if.req  = 3'b000;
        bus_if.done = 3'b000;
        test_reset();
        test_single();
        test_release();
        test_timeout();
        test_release_at_limit();
        test_ignore_non_owner();
        test_reset_mid_grant();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
